ifetch_unit: RTL and testbench

Instruction fetch stage of the MIPS core, directly upstream of the main decoder. Owns the PC, issues word requests to instruction memory over a request/ready interface, buffers returned words in a small in-order FIFO and presents them to decode with a valid/ready handshake. Handles branch/jump redirects by flushing buffered words and discarding in-flight responses.

---
 rtl/ifetch_unit.sv | 152 +++++++++++++++
 tb/tb_ifetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from instruction
// memory, buffers them in an in-order FIFO and hands them to decode.
// Ports: clk, reset (async, active-high)
//   imem_req/imem_addr/imem_ready      request side of instruction memory
//   imem_rvalid/imem_rdata             in-order response side
//   redirect/redirect_pc               branch/jump redirect pulse
//   instr/instr_pcplus4/instr_valid/instr_ready  decode handshake
// Optional feature: define IFETCH_BYPASS_EN to forward a response straight
// to decode when the FIFO is empty (zero-cycle fetch-to-decode latency).
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instr,
   output logic [31:0] instr_pcplus4,
   output logic        instr_valid,
   input  logic        instr_ready
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   logic [31:0]   pc_q, pc_d;
   logic          started_q;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] drop_q, drop_d;

   logic [31:0]   f_data_q [FIFO_DEPTH];
   logic [31:0]   f_tag_q  [FIFO_DEPTH];
   logic [AW-1:0] f_wp_q, f_wp_d;
   logic [AW-1:0] f_rp_q, f_rp_d;
   logic [CW-1:0] f_cnt_q, f_cnt_d;

   logic [31:0]   t_q [FIFO_DEPTH];
   logic [AW-1:0] t_wp_q, t_wp_d;
   logic [AW-1:0] t_rp_q, t_rp_d;

   logic [CW:0]   inflight;
   logic          issue;
   logic          rsp;
   logic          rsp_keep;
   logic          drop_nz;
   logic          fifo_ne;
   logic          push;
   logic          pop;
   logic [31:0]   tag_head;
   logic          unused_rpc;

   assign unused_rpc = ^redirect_pc[1:0];

   // Credits cover both words in flight and words already buffered,
   // so a response always has a FIFO slot waiting for it.
   assign inflight  = {1'b0, out_q} + {1'b0, f_cnt_q};
   assign imem_req  = started_q & ~redirect & (inflight < DEPTH_C);
   assign imem_addr = pc_q;
   assign issue     = imem_req & imem_ready;

   // A response with nothing outstanding is a protocol error: ignore it.
   assign rsp      = imem_rvalid & (out_q != '0);
   assign drop_nz  = (drop_q != '0);
   assign rsp_keep = rsp & ~drop_nz & ~redirect;
   assign fifo_ne  = (f_cnt_q != '0);
   assign tag_head = t_q[t_rp_q];

   always_comb begin
      instr_valid   = fifo_ne & ~redirect;
      instr         = f_data_q[f_rp_q];
      instr_pcplus4 = f_tag_q[f_rp_q];
      push          = rsp_keep;
`ifdef IFETCH_BYPASS_EN
      if (rsp_keep && !fifo_ne) begin
         instr         = imem_rdata;
         instr_pcplus4 = tag_head;
         instr_valid   = 1'b1;
         push          = ~instr_ready;
      end
`endif
   end

   assign pop = fifo_ne & instr_valid & instr_ready;

   always_comb begin
      pc_d    = pc_q;
      out_d   = out_q + CW'(issue) - CW'(rsp);
      drop_d  = drop_q - CW'(rsp & drop_nz);
      f_wp_d  = push ? f_wp_q + AW'(1) : f_wp_q;
      f_rp_d  = pop ? f_rp_q + AW'(1) : f_rp_q;
      f_cnt_d = f_cnt_q + CW'(push) - CW'(pop);
      t_wp_d  = issue ? t_wp_q + AW'(1) : t_wp_q;
      t_rp_d  = rsp_keep ? t_rp_q + AW'(1) : t_rp_q;
      if (issue) begin
         pc_d = pc_q + 32'd4;
      end
      if (redirect) begin
         // Every request still in flight after this cycle is stale.
         pc_d    = {redirect_pc[31:2], 2'b00};
         drop_d  = out_q - CW'(rsp);
         f_wp_d  = '0;
         f_rp_d  = '0;
         f_cnt_d = '0;
         t_wp_d  = '0;
         t_rp_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         started_q <= 1'b0;
         out_q     <= '0;
         drop_q    <= '0;
         f_wp_q    <= '0;
         f_rp_q    <= '0;
         f_cnt_q   <= '0;
         t_wp_q    <= '0;
         t_rp_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            f_data_q[i] <= '0;
            f_tag_q[i]  <= '0;
            t_q[i]      <= '0;
         end
      end else begin
         pc_q      <= pc_d;
         started_q <= 1'b1;
         out_q     <= out_d;
         drop_q    <= drop_d;
         f_wp_q    <= f_wp_d;
         f_rp_q    <= f_rp_d;
         f_cnt_q   <= f_cnt_d;
         t_wp_q    <= t_wp_d;
         t_rp_q    <= t_rp_d;
         if (push) begin
            f_data_q[f_wp_q] <= imem_rdata;
            f_tag_q[f_wp_q]  <= tag_head;
         end
         if (issue) begin
            t_q[t_wp_q] <= pc_q + 32'd4;
         end
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: random memory latency, stalls and
// redirects checked every cycle against a queue/epoch reference model.
module tb_ifetch_unit;

   localparam logic [31:0] RPC   = 32'h0040_0000;
   localparam int          DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instr;
   logic [31:0] instr_pcplus4;
   logic        instr_valid;
   logic        instr_ready;

   always #5 clk = ~clk;

   ifetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .instr        (instr),
      .instr_pcplus4(instr_pcplus4),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          ep;
      int          due;
   } req_t;

   typedef struct {
      logic [31:0] data;
      logic [31:0] tag;
   } word_t;

   // Model: requests in memory (tagged with the redirect epoch they belong
   // to) and the words the fetch unit should be holding for decode.
   req_t        mem_q[$];
   word_t       mf[$];
   logic [31:0] m_pc;
   bit          started;
   int          epoch;
   int          cyc;
   int          tests;
   int          fails;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input int n);
      reset       = 1'b1;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b0;
      mem_q.delete();
      mf.delete();
      m_pc    = RPC;
      started = 1'b0;
      repeat (n) begin
         #2;
         chk("rst_req", {31'b0, imem_req}, 32'd0);
         chk("rst_addr", imem_addr, RPC);
         chk("rst_valid", {31'b0, instr_valid}, 32'd0);
         chk("rst_instr", instr, 32'd0);
         chk("rst_pcp4", instr_pcplus4, 32'd0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   // mode 0: random redirect, 1: forced redirect to fpc,
   // 2: redirect only when a response and a buffered word coincide.
   task automatic cycle(input int p_rdy, input int p_ird, input int p_red,
                        input int lo, input int hi, input int mode,
                        input logic [31:0] fpc, output bit did);
      bit          rv, red, keep, byp, exp_req, exp_val, acc;
      logic [31:0] rpc;
      word_t       wd;
      word_t       w;
      rv  = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      wd  = '{data: 32'd0, tag: 32'd0};
      if (rv) wd = '{data: mem_q[0].data, tag: mem_q[0].addr + 32'd4};
      imem_rvalid = rv;
      imem_rdata  = rv ? wd.data : $urandom;
      imem_ready  = ($urandom_range(99) < p_rdy);
      instr_ready = ($urandom_range(99) < p_ird);
      rpc = $urandom;
      case (mode)
         1:       begin red = 1'b1; rpc = fpc; end
         2:       red = rv && (mf.size() > 0);
         default: red = ($urandom_range(99) < p_red);
      endcase
      redirect    = red;
      redirect_pc = rpc;
      keep = rv && !red && (mem_q[0].ep == epoch);
      byp  = 1'b0;
`ifdef IFETCH_BYPASS_EN
      byp = keep && (mf.size() == 0);
`endif
      exp_req = started && !red && (mem_q.size() + mf.size() < DEPTH);
      exp_val = ((mf.size() > 0) || byp) && !red;
      #2;
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_val});
      if (exp_val) begin
         w = byp ? wd : mf[0];
         chk("instr", instr, w.data);
         chk("instr_pcplus4", instr_pcplus4, w.tag);
      end
      acc = exp_req && imem_ready;
      if (rv) void'(mem_q.pop_front());
      if (red) begin
         mf.delete();
         epoch++;
         m_pc = {rpc[31:2], 2'b00};
      end else begin
         if (exp_val && instr_ready && !byp) void'(mf.pop_front());
         if (keep && !(byp && instr_ready)) mf.push_back(wd);
      end
      if (acc) begin
         mem_q.push_back('{addr: m_pc, data: $urandom, ep: epoch,
                           due: cyc + 1 + int'($urandom_range(hi - lo)) + lo - 1});
         m_pc = m_pc + 32'd4;
      end
      started = 1'b1;
      cyc++;
      did = red;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n, input int p_rdy, input int p_ird,
                      input int p_red, input int lo, input int hi);
      bit d;
      for (int i = 0; i < n; i++) cycle(p_rdy, p_ird, p_red, lo, hi, 0, '0, d);
   endtask

   initial begin
      bit d;
      bit found;
      tests = 0;
      fails = 0;
      epoch = 0;
      cyc   = 0;
      #1;
      do_reset(3);
      // Latency 1, decode always ready.
      run(30, 100, 100, 0, 1, 1);
      // Decode stalled, then released.
      run(8, 100, 0, 0, 1, 1);
      run(20, 100, 100, 0, 1, 2);
      // Redirect to an unaligned target with two requests in flight.
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         cycle(100, 0, 0, 3, 3, 0, '0, d);
         if (mem_q.size() == 2) found = 1'b1;
      end
      chk("two_outstanding", {31'b0, found}, 32'd1);
      cycle(100, 100, 0, 3, 3, 1, 32'h0000_0103, d);
      run(20, 100, 100, 0, 1, 2);
      // PC wrap-around at the top of the address space.
      cycle(100, 100, 0, 1, 1, 1, 32'hFFFF_FFF4, d);
      run(20, 100, 100, 0, 1, 2);
      // Redirect coinciding with a response and a valid instruction.
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         cycle(80, 30, 0, 1, 2, 2, '0, d);
         found = d;
      end
      chk("redirect_collision", {31'b0, found}, 32'd1);
      run(10, 100, 100, 0, 1, 2);
      // Long random run.
      run(3000, 70, 60, 5, 1, 4);
      // Reset in the middle of traffic.
      do_reset(2);
      run(500, 80, 70, 4, 1, 3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
